// File: rtl/fpu_cmp_pkg.sv
// Shared types and constants for the single-precision compare pipeline.
package fpu_cmp_pkg;

  typedef enum logic [1:0] {
    FCMP_EQ = 2'b00,
    FCMP_LT = 2'b01,
    FCMP_LE = 2'b10
  } fcmp_op_t;

  localparam logic [7:0] FP_EXP_MAX = 8'd255;
  localparam int         FP_MAG_W   = 31;

  // S1 payload: everything the compare core needs, pre-decoded at the input.
  // The op field is kept as raw bits because encoding 2'b11 is reserved and
  // must still travel down the pipe (it produces y=0, exc=0).
  typedef struct packed {
    logic [1:0]          op;
    logic                sign1;
    logic                sign2;
    logic [FP_MAG_W-1:0] mag1;
    logic [FP_MAG_W-1:0] mag2;
    logic                nan1;
    logic                nan2;
    logic                bothzero;
  } fcmp_s1_t;

  // NaN: all-ones exponent with a non-zero mantissa (quiet or signalling).
  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational compare core: decoded S1 payload in, {y, exc} out.
module fcmp_core
  import fpu_cmp_pkg::*;
(
  input  fcmp_s1_t s1,
  output logic     y,
  output logic     exc
);

  logic any_nan;
  logic is_eq;
  logic is_lt;

  assign any_nan = s1.nan1 | s1.nan2;

  // Equality treats +0 and -0 as equal; otherwise bitwise sign+magnitude match.
  assign is_eq = s1.bothzero || ((s1.sign1 == s1.sign2) && (s1.mag1 == s1.mag2));

  // Less-than over sign/magnitude; infinities fall out of the magnitude compare.
  always_comb begin
    is_lt = 1'b0;
    if (s1.bothzero) begin
      is_lt = 1'b0;
    end else if (s1.sign1 != s1.sign2) begin
      is_lt = s1.sign1;
    end else if (!s1.sign1) begin
      is_lt = s1.mag1 < s1.mag2;
    end else begin
      is_lt = s1.mag1 > s1.mag2;
    end
  end

  // Select result by op; any NaN operand forces y=0 and raises invalid.
  always_comb begin
    y   = 1'b0;
    exc = 1'b0;
    case (s1.op)
      FCMP_EQ: begin
        y   = any_nan ? 1'b0 : is_eq;
        exc = any_nan;
      end
      FCMP_LT: begin
        y   = any_nan ? 1'b0 : is_lt;
        exc = any_nan;
      end
      FCMP_LE: begin
        y   = any_nan ? 1'b0 : (is_lt | is_eq);
        exc = any_nan;
      end
      default: begin
        y   = 1'b0;
        exc = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage FEQ/FLT/FLE pipeline with valid/ready handshake and sticky NV flag.
module fcmp_pipe
  import fpu_cmp_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_exc,
  output logic [TAG_W-1:0] out_tag,
  input  logic             clr_nv,
  output logic             nv_sticky
);

  logic             s1_valid_reg;
  fcmp_s1_t         s1_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s2_valid_reg;
  logic             s2_y_reg;
  logic             s2_exc_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic             nv_reg;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             out_fire;
  fcmp_s1_t         s1_next;
  logic             core_y;
  logic             core_exc;

  logic [31:0]      x_in [2];
  logic [1:0]       nan_in;

  assign x_in[0] = in_x1;
  assign x_in[1] = in_x2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_nan
      assign nan_in[gi] = fp_is_nan(x_in[gi]);
    end
  endgenerate

  // Stage advance is combinational from out_ready so a full pipe streams without bubbles.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = s2_adv || !s1_valid_reg;
  assign in_ready = !flush && s1_adv;
  assign accept   = in_valid && in_ready;
  assign out_fire = s2_valid_reg && out_ready;

  // Pre-decode operands into the S1 payload.
  always_comb begin
    s1_next          = '0;
    s1_next.op       = in_op;
    s1_next.sign1    = in_x1[31];
    s1_next.sign2    = in_x2[31];
    s1_next.mag1     = in_x1[30:0];
    s1_next.mag2     = in_x2[30:0];
    s1_next.nan1     = nan_in[0];
    s1_next.nan2     = nan_in[1];
    s1_next.bothzero = (in_x1[30:0] == 31'd0) && (in_x2[30:0] == 31'd0);
  end

  fcmp_core u_core (
    .s1  (s1_reg),
    .y   (core_y),
    .exc (core_exc)
  );

  // S1 valid: cleared by reset/flush, otherwise refilled whenever the stage advances.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= accept;
    end
  end

  // S1 data: captured only on an accepted input.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_reg     <= s1_next;
      s1_tag_reg <= in_tag;
    end
  end

  // S2 valid: cleared by reset/flush, otherwise takes S1 when S2 advances.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s2_valid_reg <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // S2 data: holds while stalled so outputs stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (s2_adv) begin
      s2_y_reg   <= core_y;
      s2_exc_reg <= core_exc;
      s2_tag_reg <= s1_tag_reg;
    end
  end

  // Sticky NV: a flagged handshake beats a simultaneous clear; flush has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      nv_reg <= 1'b0;
    end else if (out_fire && s2_exc_reg) begin
      nv_reg <= 1'b1;
    end else if (clr_nv) begin
      nv_reg <= 1'b0;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_y     = s2_y_reg;
  assign out_exc   = s2_exc_reg;
  assign out_tag   = s2_tag_reg;
  assign nv_sticky = nv_reg;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed self-checking bench for fcmp_pipe.
module tb_fcmp_pipe;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic             out_exc;
  logic [TAG_W-1:0] out_tag;
  logic             clr_nv;
  logic             nv_sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fcmp_pipe #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_exc   (out_exc),
    .out_tag   (out_tag),
    .clr_nv    (clr_nv),
    .nv_sticky (nv_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_x1    = a;
    in_x2    = b;
    in_tag   = t;
  endtask

  // One isolated transaction with out_ready=1; result expected 2 edges after accept.
  task automatic single(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t,
                        input logic ey, input logic eexc);
    drive(op, a, b, t);
    step();
    in_valid = 1'b0;
    step();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_y"},     32'(out_y),     32'(ey));
    chk({name, "_exc"},   32'(out_exc),   32'(eexc));
    chk({name, "_tag"},   32'(out_tag),   32'(t));
    $display("txn %s op=%0d x1=%08h x2=%08h tag=%0d y=%0b exc=%0b", name, op, a, b, t, out_y, out_exc);
    step();
  endtask

  logic [1:0]       bp_op  [4];
  logic [31:0]      bp_x1  [4];
  logic [31:0]      bp_x2  [4];
  logic [TAG_W-1:0] bp_tag [4];
  logic             bp_y   [4];

  initial begin
    int idx;
    int outcnt;
    int seen;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_x1 = '0; in_x2 = '0; in_tag = '0; out_ready = 1'b1; clr_nv = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_nv",        32'(nv_sticky), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Back-to-back: FLT 1.0<2.0 then FLE 2.0<=1.0
    drive(2'b01, 32'h3F800000, 32'h40000000, 5'd5);
    step();
    drive(2'b10, 32'h40000000, 32'h3F800000, 5'd6);
    chk("b2b_lat_not_yet", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("b2b0_valid", 32'(out_valid), 32'd1);
    chk("b2b0_y",     32'(out_y),     32'd1);
    chk("b2b0_exc",   32'(out_exc),   32'd0);
    chk("b2b0_tag",   32'(out_tag),   32'd5);
    $display("txn b2b0 tag=%0d y=%0b", out_tag, out_y);
    step();
    chk("b2b1_valid", 32'(out_valid), 32'd1);
    chk("b2b1_y",     32'(out_y),     32'd0);
    chk("b2b1_tag",   32'(out_tag),   32'd6);
    $display("txn b2b1 tag=%0d y=%0b", out_tag, out_y);
    step();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Signed zeros, negatives, equality, reserved op
    single("feq_pz_nz", 2'b00, 32'h00000000, 32'h80000000, 5'd1, 1'b1, 1'b0);
    single("flt_nz_pz", 2'b01, 32'h80000000, 32'h00000000, 5'd2, 1'b0, 1'b0);
    single("flt_m1_m2", 2'b01, 32'hBF800000, 32'hC0000000, 5'd3, 1'b0, 1'b0);
    single("fle_m2_m1", 2'b10, 32'hC0000000, 32'hBF800000, 5'd4, 1'b1, 1'b0);
    single("fle_eq",    2'b10, 32'h3F800000, 32'h3F800000, 5'd7, 1'b1, 1'b0);
    single("rsv_nan",   2'b11, 32'h7FC00000, 32'h00000000, 5'd8, 1'b0, 1'b0);
    chk("rsv_nv", 32'(nv_sticky), 32'd0);

    // NaN sets sticky; clear alone; clear concurrent with NaN handshake
    single("feq_nan", 2'b00, 32'h7FC00000, 32'h3F800000, 5'd9, 1'b0, 1'b1);
    chk("nan_nv_set", 32'(nv_sticky), 32'd1);
    clr_nv = 1'b1;
    step();
    clr_nv = 1'b0;
    chk("nv_clr", 32'(nv_sticky), 32'd0);
    drive(2'b01, 32'h7FC00000, 32'h00000000, 5'd14);
    step();
    in_valid = 1'b0;
    step();
    chk("nan2_exc", 32'(out_exc), 32'd1);
    clr_nv = 1'b1;
    step();
    clr_nv = 1'b0;
    chk("nv_set_wins", 32'(nv_sticky), 32'd1);

    // Backpressure: 4 ops, out_ready low for 5 cycles
    bp_op[0] = 2'b01; bp_x1[0] = 32'h3F800000; bp_x2[0] = 32'h40000000; bp_tag[0] = 5'd10; bp_y[0] = 1'b1;
    bp_op[1] = 2'b00; bp_x1[1] = 32'h40400000; bp_x2[1] = 32'h40400000; bp_tag[1] = 5'd11; bp_y[1] = 1'b1;
    bp_op[2] = 2'b10; bp_x1[2] = 32'h7F800000; bp_x2[2] = 32'h7F7FFFFF; bp_tag[2] = 5'd12; bp_y[2] = 1'b0;
    bp_op[3] = 2'b01; bp_x1[3] = 32'hFF800000; bp_x2[3] = 32'h00000000; bp_tag[3] = 5'd13; bp_y[3] = 1'b1;
    idx = 0;
    outcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (outcnt == 4) break;
      out_ready = (c >= 5);
      if (idx < 4) drive(bp_op[idx], bp_x1[idx], bp_x2[idx], bp_tag[idx]);
      else in_valid = 1'b0;
      #1;
      if (c < 2) chk("bp_in_ready_hi", 32'(in_ready), 32'd1);
      if (c >= 2 && c < 5) begin
        chk("bp_in_ready_lo", 32'(in_ready), 32'd0);
        chk("bp_hold_valid",  32'(out_valid), 32'd1);
        chk("bp_hold_tag",    32'(out_tag),   32'd10);
        chk("bp_hold_y",      32'(out_y),     32'd1);
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (outcnt < 4) begin
          chk("bp_out_tag", 32'(out_tag), 32'(bp_tag[outcnt]));
          chk("bp_out_y",   32'(out_y),   32'(bp_y[outcnt]));
          $display("txn bp%0d tag=%0d y=%0b", outcnt, out_tag, out_y);
        end
        outcnt++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("bp_all_out", 32'(outcnt), 32'd4);
    #1;
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Flush with both stages full
    out_ready = 1'b0;
    drive(2'b01, 32'h3F800000, 32'h40000000, 5'd16);
    step();
    drive(2'b01, 32'h3F800000, 32'h40000000, 5'd17);
    step();
    chk("fl_full", 32'(out_valid), 32'd1);
    flush = 1'b1;
    drive(2'b01, 32'h3F800000, 32'h40000000, 5'd20);
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_valid) seen++;
    end
    chk("fl_no_stale", 32'(seen), 32'd0);
    chk("fl_nv_kept", 32'(nv_sticky), 32'd1);

    // Reset mid-stream with both stages full and NV set
    out_ready = 1'b0;
    drive(2'b00, 32'h3F800000, 32'h3F800000, 5'd21);
    step();
    drive(2'b00, 32'h3F800000, 32'h3F800000, 5'd22);
    step();
    in_valid = 1'b0;
    chk("rs_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_nv",        32'(nv_sticky), 32'd0);
    chk("rs_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (out_valid) seen++;
    end
    chk("rs_no_stale", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fcmp_pipe.md
Name: fcmp_pipe

Overview:
- Pipelined FPU compare stage (FEQ/FLT/FLE, single precision) between the FPU dispatch logic and the integer writeback path.
- Accepts operand pairs on a valid/ready handshake, produces a 1-bit result plus an invalid-operation flag two cycles later, and carries a destination tag.
- Keeps a sticky NV (invalid) flag for the fcsr.

Parameters:
TAG_W, 5, width of the pass-through destination tag (register index)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  kill all in-flight entries this cycle
in_valid  in  1  operand pair valid
in_ready  out  1  stage can accept
in_op  in  2  00 FEQ, 01 FLT, 10 FLE, 11 reserved
in_x1  in  32  operand 1 (IEEE-754 single)
in_x2  in  32  operand 2
in_tag  in  TAG_W  destination tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_y  out  1  compare result
out_exc  out  1  invalid-operation flag for this result
out_tag  out  TAG_W  tag of this result
clr_nv  in  1  clear sticky NV flag
nv_sticky  out  1  sticky NV flag

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. On reset, s1_valid, s2_valid, out_valid and nv_sticky go to 0. Data registers are don't-care. in_ready is 1 in the cycle after reset.
- Pipeline: two register stages, S1 and S2. out_* are driven directly from S2.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when S2 advances or !s1_valid.
  - in_ready = !s1_valid || s2 advances (combinational from out_ready; no bubble).
- Timing: an input accepted at edge N gives out_valid from edge N+1 (latency 2 edges). Throughput is 1 per cycle when out_ready is held high.
- Stall: with out_valid && !out_ready, S2 holds out_y/out_exc/out_tag stable. S1 fills, then in_ready drops. No entry is lost or duplicated.
- S1 contents: registered op, tag, sign bits, magnitudes (x[30:0]), nan1/nan2 (exp==255 && mant!=0), bothzero (x1[30:0]==0 && x2[30:0]==0).
- S2 arithmetic, computed by the compare core from S1:
  - Any NaN: y=0, exc=1 for FEQ, FLT and FLE.
  - FEQ: y = bothzero || (x1==x2).
  - FLT: bothzero gives 0. Signs differ gives y = sign1. Both positive gives mag1<mag2. Both negative gives mag1>mag2.
  - FLE: FLT || FEQ.
  - Infinities compare by magnitude; no special case.
  - Op 11: y=0, exc=0.
- Sticky flag:
  - nv_sticky sets at an output handshake (out_valid && out_ready) with out_exc=1.
  - clr_nv clears it.
  - If clr_nv and a setting handshake occur in the same cycle, the set wins and nv_sticky=1.
  - Flush does not touch nv_sticky.
- Flush: s1_valid and s2_valid go to 0 at the next edge. A simultaneous in_valid is not accepted: in_ready is forced 0 while flush=1. Any output handshake in the flush cycle still counts toward nv_sticky.
- Reset mid-operation: everything is discarded, identically to flush, and nv_sticky is also cleared.

Decomposition:
- Package fpu_cmp_pkg:
  - enum fcmp_op_t {FCMP_EQ=2'b00, FCMP_LT=2'b01, FCMP_LE=2'b10}
  - constants FP_EXP_MAX=8'd255, FP_MAG_W=31
  - struct fcmp_s1_t for the S1 payload.
- Sub-module fcmp_core: purely combinational, takes an fcmp_s1_t and produces {y, exc}, so verification can test the compare logic stand-alone.
- fcmp_pipe holds the handshake, the stage registers and the sticky flag.

Test Plan:
- Basic compares, out_ready=1, back-to-back:
  - FLT 0x3F800000 vs 0x40000000 -> y=1, exc=0, tag preserved, out_valid 2 edges after accept.
  - Next cycle FLE 0x40000000 vs 0x3F800000 -> y=0.
- Signed zero and negatives:
  - FEQ 0x00000000 vs 0x80000000 -> y=1.
  - FLT 0x80000000 vs 0x00000000 -> y=0.
  - FLT 0xBF800000 vs 0xC0000000 -> y=0.
  - FLE 0xC0000000 vs 0xBF800000 -> y=1.
- NaN and sticky flag:
  - FEQ 0x7FC00000 vs 0x3F800000 -> y=0, exc=1, nv_sticky=1 after handshake.
  - clr_nv asserted alone -> nv_sticky=0.
  - clr_nv in the same cycle as a NaN handshake -> nv_sticky stays 1.
- Backpressure:
  - Stream 4 ops with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, out_* stable.
  - Release out_ready -> all 4 results appear in order, none duplicated.
- Flush with S1 and S2 full: flush=1 for one cycle -> out_valid=0 next cycle, in_ready=0 during flush, no stale result emerges later.
- Reset mid-stream:
  - rst=1 with both stages full and nv_sticky=1 -> all valids=0 and nv_sticky=0 after the edge.
  - in_ready=1 the next cycle.
